uart_tx_serializer: RTL and testbench

//  UART transmit stage fed by the memory-mapped UART registers (TX data at 0x10010034,
//  TX send/status at 0x1001003C). Latches the byte written by the CPU and serializes it,
//  LSB first, on the tx line when a non-zero send strobe arrives.

---
 rtl/uart_tx_serializer_pkg.sv | 20 ++
 rtl/uart_baud_gen.sv | 34 +++
 rtl/uart_tx_serializer.sv | 139 +++++++++++++
 tb/tb_uart_tx_serializer.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/uart_tx_serializer_pkg.sv
// Shared UART definitions: transmit FSM state encoding, data width and baud divisor helper.
// Imported by uart_baud_gen and uart_tx_serializer.
package UART_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } tx_state_e;

    localparam int UART_DATA_BITS = 8;

    // Integer clock cycles per bit; callers must keep the result >= 2.
    function automatic int baud_div(input int clk_freq, input int baud);
        return clk_freq / baud;
    endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period counter: counts 0..BAUD_DIV-1 and pulses tick on the last count.
// Held at zero while clr_i is high so a frame always starts on a fresh bit period.
module uart_baud_gen #(
    parameter int BAUD_DIV = 16
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clr_i,
    output logic tick_o
);

    localparam int CW = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    assign tick_o = (cnt_q == CW'(BAUD_DIV - 1));

    always_comb begin
        cnt_d = cnt_q + CW'(1);
        if (clr_i || tick_o) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/uart_tx_serializer.sv
// UART transmit serializer: latches a CPU byte and shifts it out LSB first with start/stop bits.
// Define UART_TX_PARITY_EN to append an even parity bit between the data bits and the stop bit.
module uart_tx_serializer
    import UART_pkg::*;
#(
    parameter int CLK_FREQ = 50_000_000,
    parameter int BAUD     = 115200
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      tx_data_en,
    input  logic [UART_DATA_BITS-1:0] Tx_Data_w,
    input  logic                      tx_send_en,
    input  logic                      tx_send,
    output logic                      tx,
    output logic                      tx_busy,
    output logic                      tx_fsm_in_STOP_S
);

    localparam int BAUD_DIV = baud_div(CLK_FREQ, BAUD);

    tx_state_e                 state_q, state_d;
    logic [UART_DATA_BITS-1:0] hold_q, hold_d;
    logic [UART_DATA_BITS-1:0] shift_q, shift_d;
    logic [2:0]                bit_cnt_q, bit_cnt_d;
    logic                      tx_q, tx_d;
    logic                      tick;
`ifdef UART_TX_PARITY_EN
    logic                      par_q, par_d;
`endif

    uart_baud_gen #(
        .BAUD_DIV (BAUD_DIV)
    ) u_baud_gen (
        .clk_i  (clk),
        .rst_ni (rst),
        .clr_i  (state_q == IDLE),
        .tick_o (tick)
    );

    assign tx               = tx_q;
    assign tx_busy          = (state_q != IDLE);
    assign tx_fsm_in_STOP_S = (state_q == STOP);

    always_comb begin
        state_d   = state_q;
        hold_d    = tx_data_en ? Tx_Data_w : hold_q;
        shift_d   = shift_q;
        bit_cnt_d = bit_cnt_q;
        tx_d      = 1'b1;
`ifdef UART_TX_PARITY_EN
        par_d     = par_q;
`endif

        case (state_q)
            IDLE: begin
                // Snapshot the holding register so later CPU writes only affect the next frame.
                if (tx_send_en && tx_send) begin
                    state_d   = START;
                    shift_d   = hold_q;
                    bit_cnt_d = 3'd0;
`ifdef UART_TX_PARITY_EN
                    par_d     = ^hold_q;
`endif
                end
            end
            START: begin
                if (tick) begin
                    state_d = DATA;
                end
            end
            DATA: begin
                if (tick) begin
                    shift_d   = {1'b0, shift_q[UART_DATA_BITS-1:1]};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = STOP;
`endif
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (tick) begin
                    state_d = STOP;
                end
            end
`endif
            STOP: begin
                if (tick) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // The line is registered, so it is decoded from the state being entered.
        case (state_d)
            START:   tx_d = 1'b0;
            DATA:    tx_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
            PARITY:  tx_d = par_d;
`endif
            default: tx_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            hold_q    <= '0;
            shift_q   <= '0;
            bit_cnt_q <= 3'd0;
            tx_q      <= 1'b1;
        end else begin
            state_q   <= state_d;
            hold_q    <= hold_d;
            shift_q   <= shift_d;
            bit_cnt_q <= bit_cnt_d;
            tx_q      <= tx_d;
        end
    end

`ifdef UART_TX_PARITY_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            par_q <= 1'b0;
        end else begin
            par_q <= par_d;
        end
    end
`endif

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Directed bench for uart_tx_serializer at BAUD_DIV = 16 (CLK_FREQ=1600, BAUD=100).
// Honours UART_TX_PARITY_EN when computing the expected frame.
module tb_uart_tx_serializer;

    localparam int DIV = 16;
`ifdef UART_TX_PARITY_EN
    localparam int NBITS = 11;
`else
    localparam int NBITS = 10;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       tx_data_en = 1'b0;
    logic [7:0] Tx_Data_w = 8'h00;
    logic       tx_send_en = 1'b0;
    logic       tx_send = 1'b0;
    logic       tx;
    logic       tx_busy;
    logic       tx_fsm_in_STOP_S;

    int n_total = 0;
    int n_bad   = 0;

    uart_tx_serializer #(
        .CLK_FREQ (1600),
        .BAUD     (100)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .tx_data_en       (tx_data_en),
        .Tx_Data_w        (Tx_Data_w),
        .tx_send_en       (tx_send_en),
        .tx_send          (tx_send),
        .tx               (tx),
        .tx_busy          (tx_busy),
        .tx_fsm_in_STOP_S (tx_fsm_in_STOP_S)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [7:0] b);
        tx_data_en = 1'b1;
        Tx_Data_w  = b;
        step();
        tx_data_en = 1'b0;
    endtask

    // Strobe a send and check the whole frame cycle by cycle. mid: reload 0x3C and re-send
    // during data bit 4; late: strobe a send in the last STOP cycle.
    task automatic run_frame(input string name, input logic [7:0] b, input bit mid, input bit late);
        logic exp_bits [NBITS];
        int   tx_err, busy_cnt, stop_cnt;
        exp_bits[0] = 1'b0;
        for (int i = 0; i < 8; i++) exp_bits[i+1] = b[i];
`ifdef UART_TX_PARITY_EN
        exp_bits[9] = ^b;
`endif
        exp_bits[NBITS-1] = 1'b1;
        tx_err = 0; busy_cnt = 0; stop_cnt = 0;
        tx_send_en = 1'b1;
        tx_send    = 1'b1;
        step();
        tx_send_en = 1'b0;
        tx_send    = 1'b0;
        for (int k = 0; k < NBITS * DIV; k++) begin
            if (tx !== exp_bits[k / DIV]) tx_err++;
            if (tx_busy === 1'b1) busy_cnt++;
            if (tx_fsm_in_STOP_S === 1'b1) stop_cnt++;
            if (k % DIV == DIV / 2) chk($sformatf("%s_bit%0d", name, k / DIV), {31'd0, tx}, {31'd0, exp_bits[k / DIV]});
            if (mid && k == 5 * DIV) begin
                tx_data_en = 1'b1; Tx_Data_w = 8'h3C; tx_send_en = 1'b1; tx_send = 1'b1;
            end else begin
                tx_data_en = 1'b0; tx_send_en = 1'b0; tx_send = 1'b0;
            end
            if (late && k == NBITS * DIV - 1) begin
                tx_send_en = 1'b1; tx_send = 1'b1;
            end
            step();
        end
        tx_send_en = 1'b0;
        tx_send    = 1'b0;
        chk({name, "_tx_errs"}, tx_err, 0);
        chk({name, "_busy_cycles"}, busy_cnt, NBITS * DIV);
        chk({name, "_stop_cycles"}, stop_cnt, DIV);
        chk({name, "_idle_after"}, {31'd0, tx_busy}, 0);
        chk({name, "_tx_idle_after"}, {31'd0, tx}, 1);
    endtask

    // Check the line stays idle for n cycles.
    task automatic idle_watch(input string name, input int n);
        int bad_cyc;
        bad_cyc = 0;
        for (int k = 0; k < n; k++) begin
            if (tx !== 1'b1 || tx_busy !== 1'b0 || tx_fsm_in_STOP_S !== 1'b0) bad_cyc++;
            step();
        end
        chk({name, "_idle_errs"}, bad_cyc, 0);
    endtask

    initial begin
        // 1. reset state
        repeat (3) step();
        chk("rst_tx", {31'd0, tx}, 1);
        chk("rst_busy", {31'd0, tx_busy}, 0);
        chk("rst_stop", {31'd0, tx_fsm_in_STOP_S}, 0);
        rst = 1'b1;
        idle_watch("post_rst", 100);

        // 2. basic 0xA5 frame
        load(8'hA5);
        run_frame("a5", 8'hA5, 1'b0, 1'b0);

        // 3. send with tx_send=0 is ignored
        tx_send_en = 1'b1;
        tx_send    = 1'b0;
        step();
        tx_send_en = 1'b0;
        idle_watch("send0", 20);

        // 4. mid-frame reload + send: frame unchanged, no extra frame, next send gives 0x3C
        run_frame("a5_mid", 8'hA5, 1'b1, 1'b0);
        idle_watch("no_extra", 40);
        run_frame("3c", 8'h3C, 1'b0, 1'b0);

        // 5. reset during data bit 4
        load(8'hA5);
        tx_send_en = 1'b1;
        tx_send    = 1'b1;
        step();
        tx_send_en = 1'b0;
        tx_send    = 1'b0;
        repeat (85) step();
        chk("pre_rst_bit4", {31'd0, tx}, 0);
        chk("pre_rst_busy", {31'd0, tx_busy}, 1);
        rst = 1'b0;
        #1;
        chk("midrst_tx", {31'd0, tx}, 1);
        chk("midrst_busy", {31'd0, tx_busy}, 0);
        repeat (2) step();
        rst = 1'b1;
        idle_watch("after_midrst", 10);
        load(8'h07);
        run_frame("07", 8'h07, 1'b0, 1'b0);

        // 6. send in last STOP cycle ignored, send in first IDLE cycle starts immediately
        load(8'h81);
        run_frame("81_late", 8'h81, 1'b0, 1'b1);
        run_frame("81_b2b", 8'h81, 1'b0, 1'b0);
        idle_watch("final", 20);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
